// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S duplex port: alignment presets, channel
// encoding and the slot-window helper used by both TX and RX paths.
`ifndef GRAY
`define GRAY(x) ((x) ^ ((x) >> 1))
`endif

package i2s_pkg;
  localparam logic [4:0] ALIGN_LEFT = 5'd0;
  localparam logic [4:0] ALIGN_I2S  = 5'd1;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } ch_e;

  // True while a bit counter sits inside the data window of a slot.
  function automatic logic in_slot(input int cnt, input int lo, input int dw);
    return (cnt >= lo) && (cnt < lo + dw);
  endfunction
endpackage

// File: rtl/i2s_edge_det.sv
// Edge strobes for one already-synchronised pin: compares the current sample
// against the previous clk's sample.
module i2s_edge_det (
  input  logic clk_i,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o,
  output logic change_o
);
  logic prev_q;

  // Tracks the pin even during reset so no false edge appears on release.
  always_ff @(posedge clk_i) begin
    prev_q <= pin_i;
  end

  assign rise_o   = pin_i & ~prev_q;
  assign fall_o   = ~pin_i & prev_q;
  assign change_o = pin_i ^ prev_q;
endmodule

// File: rtl/i2s_stereo_duplex.sv
// Full-duplex stereo I2S slave: one-frame TX buffer with underrun reporting,
// RX capture with short-slot detection, programmable MSB offset.
module i2s_stereo_duplex
  import i2s_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 bclk,
  input  logic                 lrclk,
  input  logic                 rx,
  output logic                 tx,
  input  logic [4:0]           align,
  input  logic signed [DW-1:0] tx_l,
  input  logic signed [DW-1:0] tx_r,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic signed [DW-1:0] rx_l,
  output logic signed [DW-1:0] rx_r,
  output logic                 rx_valid,
  output logic                 tx_underrun,
  output logic                 rx_err
);
  logic bclk_01, bclk_10, bclk_chg;
  logic lr_01, lr_10, lr_x;

  i2s_edge_det u_bclk_edge (
    .clk_i(clk), .pin_i(bclk), .rise_o(bclk_01), .fall_o(bclk_10), .change_o(bclk_chg)
  );
  i2s_edge_det u_lr_edge (
    .clk_i(clk), .pin_i(lrclk), .rise_o(lr_01), .fall_o(lr_10), .change_o(lr_x)
  );

  logic                 synced_q, synced_d;
  ch_e                  ch_q, ch_d;
  logic [CW-1:0]        fcnt_q, fcnt_d, rcnt_q, rcnt_d;
  logic signed [DW-1:0] sreg_q, sreg_d, rsh_q, rsh_d;
  logic signed [DW-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic signed [DW-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic                 pend_full_q, pend_full_d, l_done_q, l_done_d;
  logic signed [DW-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
  logic                 rx_valid_q, rx_valid_d, tx_underrun_q, tx_underrun_d;
  logic                 rx_err_q, rx_err_d;

  always_comb begin
    synced_d      = synced_q;
    ch_d          = ch_q;
    fcnt_d        = fcnt_q;
    rcnt_d        = rcnt_q;
    sreg_d        = sreg_q;
    rsh_d         = rsh_q;
    act_l_d       = act_l_q;
    act_r_d       = act_r_q;
    pend_l_d      = pend_l_q;
    pend_r_d      = pend_r_q;
    pend_full_d   = pend_full_q;
    l_done_d      = l_done_q;
    rx_l_d        = rx_l_q;
    rx_r_d        = rx_r_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    rx_err_d      = 1'b0;

    // A slot boundary wins over any coincident bclk edge.
    if (lr_x) begin
      synced_d = 1'b1;
      ch_d     = lr_01 ? CH_R : CH_L;
      fcnt_d   = '0;
      rcnt_d   = '0;
      rsh_d    = '0;
      if (synced_q && (int'(rcnt_q) < int'(align) + DW)) rx_err_d = 1'b1;
      if (lr_10) begin
        l_done_d = 1'b0;
        if (pend_full_q) begin
          act_l_d     = pend_l_q;
          act_r_d     = pend_r_q;
          pend_full_d = 1'b0;
          sreg_d      = pend_l_q;
        end else begin
          act_l_d       = '0;
          act_r_d       = '0;
          sreg_d        = '0;
          tx_underrun_d = synced_q;
        end
      end else begin
        sreg_d = act_r_q;
      end
    end else if (synced_q && bclk_chg) begin
      if (bclk_10) begin
        if (in_slot(int'(fcnt_q), int'(align), DW)) sreg_d = sreg_q << 1;
        if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
      end
      if (bclk_01) begin
        if (in_slot(int'(rcnt_q), int'(align), DW)) rsh_d = {rsh_q[DW-2:0], rx};
        if (int'(rcnt_q) == int'(align) + DW - 1) begin
          if (ch_q == CH_L) begin
            rx_l_d   = rsh_d;
            l_done_d = 1'b1;
          end else begin
            rx_r_d     = rsh_d;
            rx_valid_d = l_done_q;
          end
        end
        if (rcnt_q != '1) rcnt_d = rcnt_q + 1'b1;
      end
    end

    // Evaluated after the slot load so a same-cycle offer refills pending.
    if (tx_valid && tx_ready) begin
      pend_l_d    = tx_l;
      pend_r_d    = tx_r;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      synced_q      <= 1'b0;
      ch_q          <= CH_L;
      fcnt_q        <= '0;
      rcnt_q        <= '0;
      sreg_q        <= '0;
      rsh_q         <= '0;
      act_l_q       <= '0;
      act_r_q       <= '0;
      pend_l_q      <= '0;
      pend_r_q      <= '0;
      pend_full_q   <= 1'b0;
      l_done_q      <= 1'b0;
      rx_l_q        <= '0;
      rx_r_q        <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_err_q      <= 1'b0;
    end else begin
      synced_q      <= synced_d;
      ch_q          <= ch_d;
      fcnt_q        <= fcnt_d;
      rcnt_q        <= rcnt_d;
      sreg_q        <= sreg_d;
      rsh_q         <= rsh_d;
      act_l_q       <= act_l_d;
      act_r_q       <= act_r_d;
      pend_l_q      <= pend_l_d;
      pend_r_q      <= pend_r_d;
      pend_full_q   <= pend_full_d;
      l_done_q      <= l_done_d;
      rx_l_q        <= rx_l_d;
      rx_r_q        <= rx_r_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      rx_err_q      <= rx_err_d;
    end
  end

  assign tx          = (synced_q && in_slot(int'(fcnt_q), int'(align), DW)) ? sreg_q[DW-1] : 1'b0;
  assign tx_ready    = ~pend_full_q;
  assign rx_l        = rx_l_q;
  assign rx_r        = rx_r_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign rx_err      = rx_err_q;
endmodule

// File: tb/tb_i2s_stereo_duplex.sv
// Codec-side bench for i2s_stereo_duplex: drives bclk/lrclk/rx, predicts every
// sampled tx bit and every output pulse from a frame-level model.
module tb_i2s_stereo_duplex;
  localparam int DW = 16;

  logic          clk = 1'b0, rst = 1'b1, enable = 1'b1;
  logic          bclk = 1'b1, lrclk = 1'b0, rx_drv = 1'b0, loop = 1'b0;
  logic [4:0]    align = 5'd1;
  logic [DW-1:0] tx_l = '0, tx_r = '0;
  logic [DW-1:0] rx_l, rx_r;
  logic          tx_valid = 1'b0;
  logic          tx, rx, tx_ready, rx_valid, tx_underrun, rx_err;

  assign rx = loop ? tx : rx_drv;

  i2s_stereo_duplex #(.DW(DW), .CW(6)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bclk(bclk), .lrclk(lrclk), .rx(rx),
    .tx(tx), .align(align), .tx_l(tx_l), .tx_r(tx_r), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_l(rx_l), .rx_r(rx_r), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, hph = 4;

  // Reference model state (frame level).
  bit            m_sync, m_pend, m_lok, m_ch;
  logic [DW-1:0] m_pl, m_pr, m_al, m_ar, m_word, m_rxw, m_rxl;
  int            m_rises;

  bit              txq[$];
  logic [2*DW-1:0] rxq[$];
  int              urq[$], erq[$];
  logic [2*DW-1:0] mon_e;
  bit              bclk_prev = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_sync = 0; m_pend = 0; m_lok = 0; m_ch = 0;
    m_al = '0; m_ar = '0; m_rises = 0; m_rxw = '0;
  endtask

  task automatic model_lr(input bit lr);
    if (m_sync && m_rises < int'(align) + DW) erq.push_back(1);
    if (!lr) begin
      m_lok = 0;
      if (m_pend) begin
        m_al = m_pl; m_ar = m_pr; m_pend = 0;
      end else begin
        m_al = '0; m_ar = '0;
        if (m_sync) urq.push_back(1);
      end
    end
    m_sync = 1; m_ch = lr; m_rises = 0; m_rxw = '0;
    m_word = lr ? m_ar : m_al;
  endtask

  task automatic model_rise(input int i);
    bit b, rb;
    int k;
    k = i - int'(align);
    b = 1'b0;
    if (m_sync && k >= 0 && k < DW) b = m_word[DW-1-k];
    txq.push_back(b);
    rb = loop ? b : rx_drv;
    if (m_sync && k >= 0 && k < DW) m_rxw = {m_rxw[DW-2:0], rb};
    if (m_sync && k == DW - 1) begin
      if (!m_ch) begin
        m_rxl = m_rxw; m_lok = 1;
      end else if (m_lok) begin
        rxq.push_back({m_rxl, m_rxw});
      end
    end
    m_rises++;
  endtask

  task automatic check_reset();
    chk("rst_tx", tx, 0);
    chk("rst_rx_l", rx_l, 0);
    chk("rst_rx_r", rx_r, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_tx_underrun", tx_underrun, 0);
    chk("rst_rx_err", rx_err, 0);
  endtask

  task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r);
    tx_l = l; tx_r = r; tx_valid = 1'b1;
    chk("tx_ready", tx_ready, !m_pend);
    if (!m_pend) begin
      m_pl = l; m_pr = r; m_pend = 1;
    end
    tick();
    tx_valid = 1'b0;
  endtask

  // One slot of n bclk periods; lrclk changes together with the first fall.
  task automatic do_slot(input bit lr, input int n, input int rst_at, input bit use_en);
    tick();
    bclk = 1'b0; lrclk = lr;
    model_lr(lr);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        tick();
        bclk = 1'b0;
      end
      rx_drv = 1'($urandom_range(0, 1));
      if (i == rst_at) begin
        if (use_en) enable = 1'b0; else rst = 1'b1;
        tick();
        check_reset();
        rst = 1'b0; enable = 1'b1;
        model_reset();
        repeat (hph - 2) tick();
      end else begin
        repeat (hph - 1) tick();
      end
      tick();
      bclk = 1'b1;
      model_rise(i);
      repeat (hph - 1) tick();
    end
  endtask

  task automatic frame(input int nl, input int nr);
    do_slot(1'b0, nl, -1, 1'b0);
    do_slot(1'b1, nr, -1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (bclk && !bclk_prev && txq.size() != 0) chk("tx_bit", tx, txq.pop_front());
    bclk_prev = bclk;
    if (rx_valid) begin
      if (rxq.size() == 0) chk("rx_valid_unexpected", rx_valid, 0);
      else begin
        mon_e = rxq.pop_front();
        chk("rx_l", rx_l, mon_e[2*DW-1:DW]);
        chk("rx_r", rx_r, mon_e[DW-1:0]);
      end
    end
    if (tx_underrun) begin
      if (urq.size() == 0) chk("tx_underrun_unexpected", tx_underrun, 0);
      else void'(urq.pop_front());
    end
    if (rx_err) begin
      if (erq.size() == 0) chk("rx_err_unexpected", rx_err, 0);
      else void'(erq.pop_front());
    end
  end

  initial begin
    int nl, nr;
    model_reset();
    repeat (3) tick();
    check_reset();
    rst = 1'b0;

    // Standard I2S loopback, plus a refused second offer.
    align = 5'd1; loop = 1'b1;
    do_slot(1'b1, 32, -1, 1'b0);
    offer(16'h8001, 16'h7FFE);
    offer(16'h1111, 16'h2222);
    frame(32, 32);

    // Starved: underrun at each left boundary, tx silent.
    frame(32, 32);
    frame(32, 32);
    chk("tx_ready_idle", tx_ready, 1);

    // Left-justified with independent rx data, then offset 8 loopback.
    align = 5'd0; loop = 1'b0;
    offer(16'hA5A5, 16'h5A5A);
    frame(32, 32);
    align = 5'd8; loop = 1'b1;
    offer(16'hA5A5, 16'h5A5A);
    frame(32, 32);

    // Short left slot.
    align = 5'd1;
    offer(16'h1234, 16'hABCD);
    frame(10, 32);
    offer(16'h1234, 16'hABCD);
    frame(32, 32);

    // Reset mid right slot, then recovery.
    offer(16'h0F0F, 16'hF0F0);
    do_slot(1'b0, 32, -1, 1'b0);
    do_slot(1'b1, 32, 5, 1'b0);
    offer(16'h4321, 16'hCAFE);
    frame(32, 32);
    frame(32, 32);

    // Enable dropped mid left slot.
    offer(16'h5555, 16'hAAAA);
    do_slot(1'b0, 32, 7, 1'b1);
    do_slot(1'b1, 32, -1, 1'b0);
    offer(16'h7777, 16'h8888);
    frame(32, 32);

    // Randomised frames.
    for (int f = 0; f < 14; f++) begin
      hph   = $urandom_range(3, 5);
      align = 5'($urandom_range(0, 8));
      loop  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) offer(DW'($urandom), DW'($urandom));
      if ($urandom_range(0, 4) == 0) offer(DW'($urandom), DW'($urandom));
      nl = ($urandom_range(0, 5) == 0) ? 10 : 32;
      nr = ($urandom_range(0, 5) == 0) ? 12 : 32;
      frame(nl, nr);
    end
    do_slot(1'b0, 32, -1, 1'b0);

    repeat (20) tick();
    chk("rx_valid_missing", rxq.size(), 0);
    chk("tx_underrun_missing", urq.size(), 0);
    chk("rx_err_missing", erq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
